// File: rtl/baseband_pkg.sv
// Shared definitions for the baseband NCO: mode encodings and default parameters.
package baseband_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_DC     = 2'd3
  } mode_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PHASE_W = 16;
  localparam int DEF_LUT_AW  = 4;
  localparam int DEF_PEAK    = 100;
  localparam int DEF_FCW_RST = 4096;

endpackage

// File: rtl/baseband_sin_rom.sv
// Full-period sine ROM, offset binary around PEAK. Contents are fixed at
// elaboration with an integer Taylor series so no real arithmetic is needed.
module baseband_sin_rom #(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 4,
  parameter int PEAK   = 100
) (
  input  logic [LUT_AW-1:0] idx_i,
  output logic [DATA_W-1:0] data_o
);

  // round(PEAK + PEAK*sin(2*pi*k/2^LUT_AW)) in Q30 fixed point.
  function automatic logic [DATA_W-1:0] sine_entry(input longint k);
    longint one, pi_q30, n, a, x, x2, term, acc, val;
    bit     neg;
    one    = longint'(1) << 30;
    pi_q30 = 64'sd3373259426;
    n      = longint'(1) << LUT_AW;
    a      = k;
    neg    = 1'b0;
    // Fold onto the first quadrant: second half is the negated first half.
    if (2 * a >= n) begin
      neg = 1'b1;
      a   = a - n / 2;
    end
    if (4 * a > n) a = n / 2 - a;
    x    = (2 * pi_q30 * a) / n;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int j = 1; j <= 7; j++) begin
      term = -(((term * x2) >>> 30) / longint'(2 * j * (2 * j + 1)));
      acc  = acc + term;
    end
    val = longint'(PEAK) * one;
    if (neg) val = val - longint'(PEAK) * acc;
    else     val = val + longint'(PEAK) * acc;
    return DATA_W'((val + (one >>> 1)) >>> 30);
  endfunction

  logic [DATA_W-1:0] rom [2**LUT_AW];

  for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
    localparam logic [DATA_W-1:0] ENTRY = sine_entry(longint'(gi));
    assign rom[gi] = ENTRY;
  end

  assign data_o = rom[idx_i];

endmodule

// File: rtl/baseband_nco.sv
// Numerically controlled baseband generator: phase accumulator with
// wrap-synchronised retuning, followed by a two-stage waveform pipeline.
module baseband_nco
  import baseband_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW  = DEF_LUT_AW,   // must not exceed PHASE_W
  parameter int PEAK    = DEF_PEAK,     // 2*PEAK must fit in DATA_W bits
  parameter int FCW_RST = DEF_FCW_RST
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_load,
  output logic               fcw_busy,
  output logic [DATA_W-1:0]  bb_out,
  output logic               bb_valid,
  output logic               wrap_tick
);

  localparam int MW = DATA_W + LUT_AW + 1;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_act_q, fcw_act_d;
  logic [PHASE_W-1:0] fcw_pend_q, fcw_pend_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   sum_w;

  logic [LUT_AW-1:0]  s1_idx_q;
  mode_e              s1_mode_q;
  logic               s1_valid_q;
  logic [DATA_W-1:0]  bb_out_q, sample_d, sin_val;
  logic               bb_valid_q;
  logic [MW-1:0]      saw_full;

  // Accumulator next state and the retune handshake around the wrap.
  always_comb begin
    sum_w      = {1'b0, phase_q} + {1'b0, fcw_act_q};
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    fcw_act_d  = fcw_act_q;
    fcw_pend_d = fcw_pend_q;
    busy_d     = busy_q;
    if (phase_clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = sum_w[PHASE_W-1:0];
      wrap_d  = sum_w[PHASE_W];
    end
    // A pending word goes live on a carry edge, or at once on a phase clear.
    if (busy_q && (phase_clr || (en && sum_w[PHASE_W]))) begin
      fcw_act_d = fcw_pend_q;
      busy_d    = 1'b0;
    end
    // A fresh load always lands after the apply above, so a load on the
    // carry edge stays pending for the following wrap.
    if (fcw_load) begin
      if (en) begin
        fcw_pend_d = fcw_in;
        busy_d     = 1'b1;
      end else begin
        fcw_act_d  = fcw_in;
        fcw_pend_d = '0;
        busy_d     = 1'b0;
      end
    end
  end

  // Accumulator and retune registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      wrap_q     <= 1'b0;
      fcw_act_q  <= PHASE_W'(FCW_RST);
      fcw_pend_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      fcw_act_q  <= fcw_act_d;
      fcw_pend_q <= fcw_pend_d;
      busy_q     <= busy_d;
    end
  end

  baseband_sin_rom #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW),
    .PEAK   (PEAK)
  ) u_rom (
    .idx_i  (s1_idx_q),
    .data_o (sin_val)
  );

  // Waveform selection for the sample held in stage 1.
  always_comb begin
    saw_full = MW'(s1_idx_q) * MW'(2 * PEAK);
    sample_d = DATA_W'(PEAK);
    case (s1_mode_q)
      MODE_SINE:   sample_d = sin_val;
      MODE_SQUARE: sample_d = s1_idx_q[LUT_AW-1] ? '0 : DATA_W'(2 * PEAK);
      MODE_SAW:    sample_d = DATA_W'(saw_full >> LUT_AW);
      MODE_DC:     sample_d = DATA_W'(PEAK);
      default:     sample_d = DATA_W'(PEAK);
    endcase
  end

  // Two-stage sample pipeline; everything freezes while en is low.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      s1_idx_q   <= '0;
      s1_mode_q  <= MODE_SINE;
      s1_valid_q <= 1'b0;
      bb_out_q   <= DATA_W'(PEAK);
      bb_valid_q <= 1'b0;
    end else if (en) begin
      s1_idx_q   <= phase_q[PHASE_W-1 -: LUT_AW];
      s1_mode_q  <= mode_e'(mode);
      s1_valid_q <= 1'b1;
      bb_out_q   <= sample_d;
      bb_valid_q <= s1_valid_q;
    end else begin
      bb_valid_q <= 1'b0;
    end
  end

  assign fcw_busy  = busy_q;
  assign bb_out    = bb_out_q;
  assign bb_valid  = bb_valid_q;
  assign wrap_tick = wrap_q;

endmodule

// File: doc/baseband_nco.md
Name: baseband_nco

Overview:
- Parametrised numerically controlled baseband generator.
- A phase accumulator addresses a full-period sine ROM, or derives square/saw/DC waveforms, and drives a registered offset-binary sample to the modulator stage.
- Adds programmable frequency, phase-continuous retuning, enable/hold, phase clear and a period tick.
- With default parameters and FCW = 4096, it emits a 16-sample, 100 ± 100 sine, one sample per clock.

Parameters:
- DATA_W, 8, output sample width.
- PHASE_W, 16, phase accumulator width.
- LUT_AW, 4, ROM address width. ROM has 2^LUT_AW entries over one period. LUT_AW <= PHASE_W.
- PEAK, 100, amplitude and midscale. Requires 2*PEAK <= 2^DATA_W - 1.
- FCW_RST, 4096, frequency control word loaded at reset.

Ports:
- clk1, in, 1, system clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, run enable. When low, phase and pipeline hold.
- phase_clr, in, 1, synchronous phase-accumulator clear.
- mode, in, 2: 0 sine, 1 square, 2 saw, 3 DC.
- fcw_in, in, PHASE_W, new frequency control word.
- fcw_load, in, 1, single-cycle strobe to request an fcw_in update.
- fcw_busy, out, 1, high while a retune is pending.
- bb_out, out, DATA_W, registered sample.
- bb_valid, out, 1, bb_out holds a new sample this cycle.
- wrap_tick, out, 1, one-cycle pulse on phase-accumulator wrap.

Behaviour:
- Reset values:
  - phase = 0
  - fcw_act = FCW_RST
  - fcw_pend = 0
  - fcw_busy = 0
  - bb_out = PEAK
  - bb_valid = 0
  - wrap_tick = 0
  - pipeline stages cleared, valid bits 0.
- Accumulator: on each edge with en = 1, phase <= (phase + fcw_act) mod 2^PHASE_W. wrap_tick <= carry-out of that add. With en = 0, phase holds and wrap_tick <= 0.
- phase_clr = 1 sets phase <= 0 and wrap_tick <= 0, regardless of en. phase_clr has priority over accumulation. It does not flush the pipeline.
- Index: idx = phase[PHASE_W-1 : PHASE_W-LUT_AW], taken from the registered phase.
- Pipeline, latency 2 edges from the phase register to bb_out:
  - Stage 1 registers idx, mode and valid (= en).
  - Stage 2 computes the sample and registers it into bb_out; bb_valid <= stage-1 valid.
  - All stages advance only when en = 1. With en = 0, bb_out holds and bb_valid <= 0.
- Sample rules, using unsigned arithmetic with at least DATA_W+LUT_AW bits internally:
  - Sine: ROM[idx] = round(PEAK + PEAK*sin(2*pi*idx/2^LUT_AW)).
  - Square: idx MSB = 0 gives 2*PEAK; otherwise 0.
  - Saw: (idx * 2*PEAK) >> LUT_AW.
  - DC: PEAK.
- mode is sampled per sample at stage 1. A mode change takes effect on the sample 2 edges later, with no glitch or flush.
- Retune handshake:
  - With en = 1, fcw_load writes fcw_pend <= fcw_in and sets fcw_busy.
  - On the first subsequent edge where the accumulator add carries out, fcw_act <= fcw_pend and fcw_busy clears. The new word is used for the add following the wrap.
  - fcw_load coincident with a carry edge goes to pending only. It is not applied on that wrap.
  - fcw_load while busy overwrites fcw_pend; busy stays high.
  - With en = 0, fcw_load updates fcw_act directly on the next edge, clears any pending request, and leaves fcw_busy = 0.
  - phase_clr while busy applies fcw_pend immediately and clears busy.
- FCW = 0 is legal: phase freezes, samples repeat, bb_valid stays high while en = 1, and no wrap occurs.
- Reset mid-operation returns everything to reset values immediately and discards any pending retune.

Decomposition:
- Shared package baseband_pkg holds:
  - mode encodings: MODE_SINE, MODE_SQUARE, MODE_SAW, MODE_DC.
  - default parameter constants.
- Sub-module baseband_sin_rom:
  - parameters DATA_W, LUT_AW, PEAK.
  - combinational ROM, contents computed at elaboration.

Test Plan:
- Reset, then en = 1, mode = 0, default FCW. Required: bb_valid rises 2 edges after en, then bb_out = 100, 138, 171, 192, 200, 192, 171, 138, 100, 62, 29, 8, 0, 8, 29, 62 repeating. wrap_tick pulses every 16 cycles.
- mode = 2 (saw), default FCW. Required: idx 0, 1, 8, 15 give 0, 12, 100, 187. mode = 1 (square) gives 200 for idx 0–7 and 0 for idx 8–15.
- en = 1, fcw_load with fcw_in = 8192 at idx 5. Required: fcw_busy high until wrap, no change mid-period, then period 8 samples (100, 171, 200, 171, 100, 29, 0, 29); busy clears on the wrap edge.
- Two fcw_load pulses (2048, then 8192) before a wrap. Required: only 8192 applied. A load on the exact carry edge is deferred to the next wrap.
- en low for 5 cycles mid-period. Required: bb_out held, bb_valid 0, sequence resumes without skipped index. A fcw_load while en = 0 takes effect immediately with busy = 0.
- Assert rst asynchronously mid-period with retune pending. Required: outputs return to bb_out = 100, valid 0, busy 0 without a clock edge. phase_clr restarts the sequence at 100.
